mem_bridge: RTL and testbench

Parametrised memory access sequencer between the multicycle CPU core and external memory. It replaces the single-cycle `wr`/`data_bus` scheme with a registered request/done handshake, a tri-phase bus cycle (setup, access, hold), variable wait states driven by `mem_ready`, and an optional access watchdog. Instruction fetches and data loads/stores from the controller share this one port.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mem_wait_timer.sv | 34 +++
 rtl/mem_bridge.sv | 112 +++++++++++
 tb/tb_mem_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared memory-sequencer state encoding and default widths      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    HOLD   = 2'b11
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wait_timer : ACCESS-phase watchdog counter for mem_bridge            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] count;

  // Fires on the wait cycle whose increment brings the count up to MAX_WAIT.
  assign expired = inc && (count == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != WAIT_W'(MAX_WAIT))) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bridge : req/done memory sequencer, SETUP/ACCESS/HOLD bus cycle      |
// | Optional watchdog: define MEM_BRIDGE_TIMEOUT_EN                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bridge
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic              mem_oe,
  input  logic              mem_ready
);

  mem_state_t state;
  logic       wr_flag;
  logic       expired;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic wait_clr;
  logic wait_inc;

  assign wait_clr = (state == SETUP);
  assign wait_inc = (state == ACCESS) && !mem_ready;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (expired)
  );
`else
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] unused_max_wait;
  assign unused_max_wait = WAIT_W'(MAX_WAIT);
  assign expired         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_flag   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      mem_oe    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= SETUP;
            busy      <= 1'b1;
            wr_flag   <= we;
            mem_addr  <= addr;
            mem_wdata <= wdata;
          end
        end
        SETUP: begin
          state  <= ACCESS;
          mem_wr <= wr_flag;
          mem_oe <= !wr_flag;
        end
        ACCESS: begin
          // mem_ready takes priority over a watchdog expiry in the same cycle.
          if (mem_ready || expired) begin
            state  <= HOLD;
            mem_wr <= 1'b0;
            mem_oe <= 1'b0;
            done   <= 1'b1;
            err    <= !mem_ready;
            if (!wr_flag) begin
              rdata <= mem_ready ? mem_rdata : '1;
            end
          end
        end
        HOLD: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_bridge : directed self-checking bench for mem_bridge              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_bridge;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_wr;
  logic        mem_oe;
  logic        mem_ready;

  int n_vec;
  int n_miscmp;

  mem_bridge #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .MAX_WAIT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_oe    (mem_oe),
    .mem_ready (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and services it as a memory that raises mem_ready
  // after 'delay' low ACCESS cycles (delay < 0: never). Runs 30 sample cycles.
  task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                            input int delay, input logic [15:0] rd,
                            output int done_k, output int oe_cnt, output int wr_cnt,
                            output int done_cnt, output logic err_at_done,
                            output logic stable_ok);
    int acc;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; mem_rdata = rd; mem_ready = 1'b1;
    done_k = -1; oe_cnt = 0; wr_cnt = 0; done_cnt = 0; acc = 0;
    err_at_done = 1'b0; stable_ok = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
      if (mem_oe) oe_cnt++;
      if (mem_wr) wr_cnt++;
      if (mem_oe || mem_wr) begin
        acc++;
        mem_ready = (delay >= 0) && (acc > delay);
      end else begin
        mem_ready = 1'b1;
      end
      if (busy && ((mem_addr !== a) || (w && (mem_wdata !== d)))) stable_ok = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k      = k;
          err_at_done = err;
        end
      end
    end
  endtask

  int          dk, oc, wc, dc, n_acc, done_seen;
  logic        e, st, prev_busy;
  int          acc_k [4];
  logic [15:0] acc_addr [4];

  initial begin
    n_vec = 0; n_miscmp = 0;
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 1'($urandom); we = 1'($urandom); addr = 16'($urandom);
      wdata = 16'($urandom); mem_rdata = 16'($urandom); mem_ready = 1'($urandom);
    end
    check("rst_ctrl",  {27'd0, busy, done, err, mem_wr, mem_oe}, 32'd0);
    check("rst_data",  {rdata, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ctrl", {27'd0, busy, done, err, mem_wr, mem_oe}, 32'd0);
    check("idle_data", {rdata, mem_addr}, 32'd0);

    // Zero-wait load
    run_access(1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, dk, oc, wc, dc, e, st);
    check("ld_done_k",  dk, 3);
    check("ld_oe_cnt",  oc, 1);
    check("ld_wr_cnt",  wc, 0);
    check("ld_done_cnt", dc, 1);
    check("ld_err",     {31'd0, e}, 0);
    check("ld_rdata",   {16'd0, rdata}, 32'h0000BEEF);
    check("ld_stable",  {31'd0, st}, 1);

    // Store with four wait states
    run_access(1'b1, 16'h0100, 16'h1234, 4, 16'h5A5A, dk, oc, wc, dc, e, st);
    check("st_done_k",  dk, 7);
    check("st_wr_cnt",  wc, 5);
    check("st_oe_cnt",  oc, 0);
    check("st_err",     {31'd0, e}, 0);
    check("st_rdata",   {16'd0, rdata}, 32'h0000BEEF);
    check("st_stable",  {31'd0, st}, 1);

    // Back-to-back with req held high
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h2000; mem_ready = 1'b1; mem_rdata = 16'h7777;
    prev_busy = busy; n_acc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy && !prev_busy && (n_acc < 4)) begin
        acc_k[n_acc]    = k;
        acc_addr[n_acc] = mem_addr;
        n_acc++;
      end
      prev_busy = busy;
      addr = 16'h2000 + 16'(k);
    end
    req = 1'b0;
    check("b2b_count", n_acc, 3);
    if (n_acc == 3) begin
      check("b2b_gap0",  acc_k[1] - acc_k[0], 4);
      check("b2b_gap1",  acc_k[2] - acc_k[1], 4);
      check("b2b_addr1", {16'd0, acc_addr[1]}, 32'h00002004);
      check("b2b_addr2", {16'd0, acc_addr[2]}, 32'h00002008);
    end
    repeat (4) @(negedge clk);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    run_access(1'b0, 16'h0200, 16'h0000, -1, 16'h5555, dk, oc, wc, dc, e, st);
    check("to_done_k", dk, 5);
    check("to_oe_cnt", oc, 3);
    check("to_err",    {31'd0, e}, 1);
    check("to_rdata",  {16'd0, rdata}, 32'h0000FFFF);
    run_access(1'b0, 16'h0204, 16'h0000, 2, 16'h0A0A, dk, oc, wc, dc, e, st);
    check("tr_done_k", dk, 5);
    check("tr_err",    {31'd0, e}, 0);
    check("tr_rdata",  {16'd0, rdata}, 32'h00000A0A);
`else
    run_access(1'b0, 16'h0200, 16'h0000, 20, 16'h6666, dk, oc, wc, dc, e, st);
    check("lw_done_k", dk, 23);
    check("lw_oe_cnt", oc, 21);
    check("lw_err",    {31'd0, e}, 0);
    check("lw_rdata",  {16'd0, rdata}, 32'h00006666);
`endif

    // Reset in the second ACCESS cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0300; mem_ready = 1'b0; mem_rdata = 16'h9999;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_pre_oe", {31'd0, mem_oe}, 1);
    reset = 1'b0;
    #1;
    check("mid_oe",   {31'd0, mem_oe}, 0);
    check("mid_busy", {31'd0, busy}, 0);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mid_no_done", done_seen, 0);
    check("mid_rdata",   {16'd0, rdata}, 32'd0);

    // Normal access after the aborted one
    run_access(1'b0, 16'h0400, 16'h0000, 1, 16'hC0DE, dk, oc, wc, dc, e, st);
    check("post_done_k", dk, 4);
    check("post_rdata",  {16'd0, rdata}, 32'h0000C0DE);
    check("post_err",    {31'd0, e}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
